imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
Sequencer that owns the 64-word instruction memory port. It has two jobs:
- Boot-time program loader: streams words into the instruction memory.
- Run-time fetch unit: holds the PC, reads one word per cycle and presents it to decode through a valid/ready handshake.

It handles branch redirect, stall, halt detection and sticky fault reporting. It sits between the loader/debug interface, the instruction memory and the decode stage of the single-clock CPU.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory (depth = 2**ADDR_W).
- RESET_PC, 32'h0000_0000, byte address of the first fetch after load.
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetching.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset; synchronous, active-low.
- load_en  in  1  high = stay in / enter load mode (sampled in IDLE and LOAD only).
- load_valid  in  1  load_data holds a word to store.
- load_data  in  32  program word.
- load_ready  out  1  controller accepts a word this cycle.
- imem_a  out  ADDR_W  word address to the instruction memory.
- imem_we  out  1  write strobe to the instruction memory.
- imem_wd  out  32  write data to the instruction memory.
- imem_rd  in  32  combinational read data (same-cycle as imem_a).
- branch_taken  in  1  redirect request from execute.
- branch_target  in  32  redirect byte address.
- instr_out  out  32  fetched instruction.
- pc_out  out  32  byte address of instr_out.
- instr_valid  out  1  instr_out/pc_out valid.
- instr_ready  in  1  decode consumes instr_out this cycle.
- halted  out  1  HALT state.
- fault  out  1  FAULT state.

Behaviour:

Reset (reset_n=0 at a rising edge):
- state=IDLE, pc=RESET_PC, load_ptr=0.
- instr_out=0, pc_out=0, instr_valid=0, halted=0, fault=0, load_ready=0.
- Reset mid-load or mid-fetch discards all progress; memory contents are untouched.

Combinational outputs:
- imem_a = load_ptr in LOAD, otherwise pc[ADDR_W+1:2].
- imem_wd = load_data.
- imem_we = load_valid & load_ready.
- load_ready = (state==LOAD) & (load_ptr < 2**ADDR_W). load_ptr is ADDR_W+1 bits wide so it can reach 2**ADDR_W.

IDLE:
- load_en=1 -> LOAD.
- Otherwise -> RUN.

LOAD:
- Each accepted word (load_valid & load_ready) writes mem[load_ptr] and increments load_ptr.
- Once load_ptr = 2**ADDR_W, load_ready=0 and extra words are ignored with no write.
- load_en=0 -> RUN next cycle, with pc=RESET_PC and load_ptr=0. A word accepted in that same cycle is still written.

RUN, evaluated with priority 1 > 2 > 3 > 4:
1. branch_taken=1:
   - branch_target[1:0]!=0, or branch_target[31:ADDR_W+2]!=0 -> FAULT, instr_valid=0.
   - Otherwise pc=branch_target and instr_valid=0 (flush), even if decode is stalling.
   - First redirected instruction is valid 1 cycle later (one-bubble penalty).
2. pc[31:ADDR_W+2]!=0, i.e. sequential fetch ran off the end -> FAULT, instr_valid=0.
3. instr_valid=1 and instr_ready=0 -> stall: pc, instr_out, pc_out and instr_valid all hold.
4. Otherwise (instr_valid=0 or instr_ready=1) -> fetch:
   - imem_rd==HALT_WORD: instr_valid=0, pc holds, state=HALT. The halt word is never presented.
   - Else: instr_out=imem_rd, pc_out=pc, instr_valid=1, pc=pc+4 (32-bit wrap, then caught by rule 2).
   - Throughput is one instruction per cycle while instr_ready=1.

HALT:
- halted=1, instr_valid=0; branch_taken is ignored.
- Exit only by reset.

FAULT:
- fault=1 (sticky), instr_valid=0; all inputs are ignored.
- Exit only by reset.

Test Plan:
1. Reset with load_en=1, stream 4 words (0x11,0x22,0x33,0x44) with load_valid held high -> imem_we pulses 4 cycles at imem_a 0..3. Drop load_en -> first valid instr_out=0x11, pc_out=0, then 0x22 and pc_out=4 on consecutive cycles.
2. RUN with instr_ready=0 for 3 cycles after the first valid -> instr_out=0x11 and pc_out=0 held, pc unchanged. Raise ready -> 0x22 follows the next cycle.
3. branch_taken with target 0x20 while stalled -> instr_valid=0 next cycle, then pc_out=0x20 with instr_out=mem[8].
4. mem[2]=HALT_WORD -> 0x11 and 0x22 presented, then instr_valid stays 0 and halted=1. A later branch_taken has no effect.
5. Branch target 0x22 (misaligned), and separately 0x100 (out of range) -> fault=1 the next cycle, instr_valid=0, sticky until reset_n=0.
6. Load 70 words -> exactly 64 writes; load_ready=0 after the 64th. Assert reset_n=0 mid-stream -> state IDLE, load_ready=0, all outputs at reset values.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: boot-time program loader plus run-time fetch unit
// with branch redirect, decode back-pressure, halt detection and sticky fault.
module imem_fetch_ctrl #(
   parameter int          ADDR_W    = 6,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_en,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   output logic              load_ready,
   output logic [ADDR_W-1:0] imem_a,
   output logic              imem_we,
   output logic [31:0]       imem_wd,
   input  logic [31:0]       imem_rd,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   output logic [31:0]       instr_out,
   output logic [31:0]       pc_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              halted,
   output logic              fault
);

   // state | meaning
   // IDLE  | one cycle after reset, picks LOAD or RUN from load_en
   // LOAD  | streaming program words into the memory
   // RUN   | fetching one word per cycle towards decode
   // HALT  | halt word fetched, waiting for reset
   // FAULT | bad redirect or fetch beyond memory, waiting for reset
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      HALT  = 3'd3,
      FAULT = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

   state_t          state;
   logic [31:0]     pc;
   logic [ADDR_W:0] load_ptr;
   logic            word_accept;
   logic            target_bad;
   logic            pc_overrun;

   // load_ptr only ever counts up to 2**ADDR_W, so its MSB marks a full memory
   assign load_ready  = (state == LOAD) & ~load_ptr[ADDR_W];
   assign word_accept = load_valid & load_ready;
   assign imem_we     = word_accept;
   assign imem_wd     = load_data;
   assign imem_a      = (state == LOAD) ? load_ptr[ADDR_W-1:0] : pc[ADDR_W+1:2];

   assign target_bad  = (branch_target[1:0] != 2'b00) | (branch_target[31:ADDR_W+2] != '0);
   assign pc_overrun  = (pc[31:ADDR_W+2] != '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         load_ptr    <= '0;
         instr_out   <= '0;
         pc_out      <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= load_en ? LOAD : RUN;
            end
            LOAD: begin
               if (word_accept) begin
                  load_ptr <= load_ptr + PTR_ONE;
               end
               if (!load_en) begin
                  state    <= RUN;
                  pc       <= RESET_PC;
                  load_ptr <= '0;
               end
            end
            RUN: begin
               if (branch_taken) begin
                  instr_valid <= 1'b0;
                  if (target_bad) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     pc <= branch_target;
                  end
               end else if (pc_overrun) begin
                  instr_valid <= 1'b0;
                  state       <= FAULT;
                  fault       <= 1'b1;
               end else if (!instr_valid || instr_ready) begin
                  // halt word is swallowed here and never shown to decode
                  if (imem_rd == HALT_WORD) begin
                     instr_valid <= 1'b0;
                     state       <= HALT;
                     halted      <= 1'b1;
                  end else begin
                     instr_out   <= imem_rd;
                     pc_out      <= pc;
                     instr_valid <= 1'b1;
                     pc          <= pc + 32'd4;
                  end
               end
            end
            HALT: begin
               instr_valid <= 1'b0;
            end
            FAULT: begin
               instr_valid <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
